// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised
// write lanes with same-cycle bypass, and a busy-bit scoreboard for reservations.
module register_file_mp #(
    parameter int Index_size = 4,
    parameter int width      = 32,
    parameter int NUM_RD     = 3,
    parameter int ZERO_REG   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_RD-1:0][Index_size-1:0]   ra,
    output logic [NUM_RD-1:0][width-1:0]        rd,
    output logic [NUM_RD-1:0]                   rbusy,
    input  logic                                we0,
    input  logic [Index_size-1:0]               wa0,
    input  logic [width-1:0]                    wd0,
    input  logic                                we1,
    input  logic [Index_size-1:0]               wa1,
    input  logic [width-1:0]                    wd1,
    input  logic                                res_en,
    input  logic [Index_size-1:0]               res_idx,
    output logic                                busy_any
);

    localparam int DEPTH = 2 ** Index_size;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [width-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic             w_wr0Ok;
    logic             w_wr1Ok;
    logic             w_resOk;
    logic [DEPTH-1:0] w_busyNext;

    // Index 0 swallows writes and reservations when it is hardwired to zero.
    assign w_wr0Ok = we0 && !(HAS_ZERO && (wa0 == '0));
    assign w_wr1Ok = we1 && !(HAS_ZERO && (wa1 == '0));
    assign w_resOk = res_en && !(HAS_ZERO && (res_idx == '0));

    // Writes retire a result (clear busy); a same-cycle reservation re-arms it.
    always_comb begin
        w_busyNext = r_busy;
        if (w_wr0Ok) w_busyNext[wa0] = 1'b0;
        if (w_wr1Ok) w_busyNext[wa1] = 1'b0;
        if (w_resOk) w_busyNext[res_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr0Ok) r_regs[wa0] <= wd0;
            if (w_wr1Ok) r_regs[wa1] <= wd1;
            r_busy <= w_busyNext;
        end
    end

    // Lane 1 outranks lane 0 in the bypass, mirroring which value gets stored.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd[p]    = r_regs[ra[p]];
            rbusy[p] = r_busy[ra[p]];
            if (HAS_ZERO && (ra[p] == '0)) begin
                rd[p]    = '0;
                rbusy[p] = 1'b0;
            end else if (we1 && (wa1 == ra[p])) begin
                rd[p]    = wd1;
                rbusy[p] = 1'b0;
            end else if (we0 && (wa0 == ra[p])) begin
                rd[p]    = wd0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign busy_any = |r_busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: a driver pushes expected read results
// computed from an array model; a negedge monitor pops and compares.
module tb_register_file_mp;

    localparam int IDX   = 4;
    localparam int W     = 32;
    localparam int NRD   = 3;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [NRD-1:0][W-1:0] rd;
        logic [NRD-1:0]        rbusy;
        logic                  busyAny;
        int                    cycle;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NRD-1:0][IDX-1:0]    ra;
    logic [NRD-1:0][W-1:0]      rd;
    logic [NRD-1:0]             rbusy;
    logic                       we0, we1, res_en;
    logic [IDX-1:0]             wa0, wa1, res_idx;
    logic [W-1:0]               wd0, wd1;
    logic                       busy_any;

    logic [W-1:0] mRegs [DEPTH];
    bit           mBusy [DEPTH];
    exp_t         expQ [$];
    int           testsRun = 0;
    int           testsFailed = 0;
    int           cycleNo = 0;

    register_file_mp #(.Index_size(IDX), .width(W), .NUM_RD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .res_en(res_en), .res_idx(res_idx), .busy_any(busy_any)
    );

    always #5 clk = ~clk;

    // Read rule straight from the behavioural description, in priority order.
    function automatic void modelRead(input int a, output logic [W-1:0] d, output logic b);
        if (a == 0) begin
            d = '0; b = 1'b0;
        end else if (we1 && int'(wa1) == a) begin
            d = wd1; b = 1'b0;
        end else if (we0 && int'(wa0) == a) begin
            d = wd0; b = 1'b0;
        end else begin
            d = mRegs[a]; b = mBusy[a];
        end
    endfunction

    task automatic applyStimulus(input logic r, input logic e0, input int a0, input logic [W-1:0] d0,
                                 input logic e1, input int a1, input logic [W-1:0] d1,
                                 input logic re, input int ri, input int p0, input int p1, input int p2);
        exp_t e;
        int   anyBusy;
        @(posedge clk);
        #1;
        rst = r; we0 = e0; wa0 = 4'(a0); wd0 = d0;
        we1 = e1; wa1 = 4'(a1); wd1 = d1;
        res_en = re; res_idx = 4'(ri);
        ra[0] = 4'(p0); ra[1] = 4'(p1); ra[2] = 4'(p2);
        cycleNo++;
        for (int p = 0; p < NRD; p++) begin
            modelRead(int'(ra[p]), e.rd[p], e.rbusy[p]);
        end
        anyBusy = 0;
        for (int i = 0; i < DEPTH; i++) anyBusy += int'(mBusy[i]);
        e.busyAny = (anyBusy != 0);
        e.cycle = cycleNo;
        expQ.push_back(e);
        // Advance the model to the state after the coming edge.
        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin mRegs[i] = '0; mBusy[i] = 1'b0; end
        end else begin
            if (e0 && a0 != 0) begin mRegs[a0] = d0; mBusy[a0] = 1'b0; end
            if (e1 && a1 != 0) begin mRegs[a1] = d1; mBusy[a1] = 1'b0; end
            if (re && ri != 0) mBusy[ri] = 1'b1;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        for (int p = 0; p < NRD; p++) begin
            testsRun++;
            if (rd[p] !== e.rd[p]) begin
                testsFailed++;
                $display("[TB] FAIL rd[%0d] cycle %0d: got %h, expected %h", p, e.cycle, rd[p], e.rd[p]);
            end
            testsRun++;
            if (rbusy[p] !== e.rbusy[p]) begin
                testsFailed++;
                $display("[TB] FAIL rbusy[%0d] cycle %0d: got %b, expected %b", p, e.cycle, rbusy[p], e.rbusy[p]);
            end
        end
        testsRun++;
        if (busy_any !== e.busyAny) begin
            testsFailed++;
            $display("[TB] FAIL busy_any cycle %0d: got %b, expected %b", e.cycle, busy_any, e.busyAny);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin : driver
        rst = 1'b1; we0 = 0; we1 = 0; res_en = 0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; res_idx = '0; ra = '0;
        for (int i = 0; i < DEPTH; i++) begin mRegs[i] = '0; mBusy[i] = 1'b0; end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Every index reads zero and not busy after reset.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, i, 15 - i, (i + 5) % 16);

        // Lane 0 bypass, then held in state.
        applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 4);

        // Both lanes to index 3: lane 1 wins in bypass and in storage.
        applyStimulus(0, 1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 3, 2, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 5);

        // Reserve 7, see it next cycle, then clear by lane 1 write.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 7);
        applyStimulus(0, 0, 0, 0, 1, 7, 32'h5, 0, 0, 7, 6, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 3, 5);

        // Index 0 ignores writes and reservations.
        applyStimulus(0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 5, 0);

        // Reserve and write 9 together, then reset while busy.
        applyStimulus(0, 1, 9, 32'hCAFE0009, 0, 0, 0, 1, 9, 9, 0, 9);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9);
        applyStimulus(1, 1, 9, 32'h1234, 0, 0, 0, 1, 4, 9, 4, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 4, 3);
        applyStimulus(0, 1, 9, 32'h77, 0, 0, 0, 0, 0, 9, 9, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 0);

        // Randomized traffic with occasional resets; addresses biased to collide.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          logic'($urandom_range(0, 1)), int'($urandom_range(0, 15)), W'($urandom),
                          logic'($urandom_range(0, 1)), int'($urandom_range(0, 15)), W'($urandom),
                          logic'($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3);

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        if (expQ.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Multi-port register file for the pipelined core datapath, the next generation of the single-write register bank. It has a configurable number of combinational read ports, two prioritised write ports with same-cycle write-to-read bypass, and a per-register scoreboard of busy bits for in-flight multi-cycle results. Register 0 is optionally hardwired to zero. It sits between decode (reads, reservations) and writeback (two retirement lanes).

## Interface
- `Index_size`, 4 — address bits; depth = 2**Index_size registers.
- `width`, 32 — register width in bits.
- `NUM_RD`, 3 — number of read ports (1..4).
- `ZERO_REG`, 1 — 1: register 0 reads as 0; writes and reservations to it are ignored.
- `clk` input 1 — single clock; all state updates on posedge.
- `rst` input 1 — synchronous, active-high reset.
- `ra` input NUM_RD×Index_size — read addresses, packed; port i = `ra[i]`.
- `rd` output NUM_RD×width — read data, combinational.
- `rbusy` output NUM_RD — busy flag of the addressed register, combinational.
- `we0`, `wa0`, `wd0` input 1 / Index_size / width — write lane 0.
- `we1`, `wa1`, `wd1` input 1 / Index_size / width — write lane 1, higher priority.
- `res_en`, `res_idx` input 1 / Index_size — reserve the register by setting its busy bit.
- `busy_any` output 1 — OR of all busy bits, combinational from state.

## Operation
- Storage: 2**Index_size × width flops and 2**Index_size busy bits.
- Write commit at posedge when `we0`/`we1` is set: `reg[wa] <= wd` and `busy[wa] <= 0`.
- Write lanes to the same address in one cycle: lane 1 data is stored; busy is cleared once.
- Reservation at posedge when `res_en` is set: `busy[res_idx] <= 1`.
- Reservation and write to the same index in one cycle: data is stored and busy ends 1, because reserve wins.
- Read port i, evaluated in priority order:
  1. `ZERO_REG` set and `ra[i] == 0`: return 0, not busy.
  2. `we1` set and `wa1 == ra[i]`: return `wd1`, not busy.
  3. `we0` set and `wa0 == ra[i]`: return `wd0`, not busy.
  4. Otherwise: return `reg[ra[i]]` and `busy[ra[i]]`.
- Bypass does not consider same-cycle `res_en`; a reservation becomes visible in `rbusy` from the next cycle.
- `ZERO_REG = 1`: writes and reservations to index 0 are dropped; `busy[0]` is always 0.
- `ZERO_REG = 0`: register 0 behaves like any other register.

## Timing
- Reset, when `rst` is high at posedge: all registers become 0 and all busy bits become 0. `rst` overrides same-cycle writes and reservations.
- After reset with idle inputs: every `rd` = 0, `rbusy` = 0, `busy_any` = 0.
- Read latency is 0 cycles (combinational from `ra` and write lanes). Committed data is visible from state one cycle after the write.
- Reservation to busy-visible latency is 1 cycle. Write-to-clear is bypassed in the same cycle, then held in state.
- Reset asserted while registers are busy: all busy bits clear. Writes from older producers arriving after reset are accepted normally.
- No handshake and no backpressure: every asserted write and reserve is accepted.

## Test plan
- Reset, then read all indices -> `rd` = 0, `rbusy` = 0 and `busy_any` = 0 on all ports.
- `we0=1, wa0=5, wd0=32'hDEADBEEF`, `ra[0]=5` in the same cycle -> `rd[0]=32'hDEADBEEF` immediately (bypass). With `we0=0` next cycle -> `rd[0]` still `32'hDEADBEEF`.
- Both lanes write index 3 (`wd0=32'h11`, `wd1=32'h22`) -> bypass returns `32'h22` and the stored value is `32'h22`.
- `res_en=1, res_idx=7`, then next cycle -> `rbusy` for index 7 = 1 and `busy_any` = 1. Then `we1`, `wa1=7`, `wd1=32'h5` -> same cycle `rbusy=0`, `rd=32'h5`; next cycle `busy_any` = 0.
- `ZERO_REG=1`: write `32'hFFFF` to index 0 and reserve index 0 -> reads of index 0 return 0 and not busy, before and after the clock edge.
- Same-cycle `res_en` and `we0` to index 9 -> next cycle data = `wd0` and busy = 1. Assert `rst` while 9 is busy -> busy cleared and `rd` = 0 next cycle.
